// File: rtl/scratch_ram_pkg.sv
// scratch_ram_pkg: shared sizes and types for the RAT CPU scratch memory.
// Contents:
//   SCR_DATA_W / SCR_ADDR_W / SCR_DEPTH  word width, address width, word count
//   scr_data_t / scr_addr_t              convenience types for drivers of the RAM
package scratch_ram_pkg;
    localparam int SCR_DATA_W = 10;
    localparam int SCR_ADDR_W = 8;
    localparam int SCR_DEPTH  = 2 ** SCR_ADDR_W;
    typedef logic [SCR_DATA_W-1:0] scr_data_t;
    typedef logic [SCR_ADDR_W-1:0] scr_addr_t;
endpackage

// File: rtl/scratch_ram.sv
// scratch_ram: 256 x 10-bit flop-based scratch memory, sync write, async read, async clear.
// Ports:
//   CLK       in   rising-edge write clock
//   RST       in   asynchronous active-high clear of every word
//   DATA_IN   in   write data (DATA_WIDTH)
//   SCR_ADDR  in   shared read/write address (ADDR_WIDTH)
//   SCR_WE    in   write enable, sampled on rising CLK
//   DATA_OUT  out  combinational read of the word at SCR_ADDR
// Build option: define SCRATCH_RAM_BYPASS_EN to forward DATA_IN to DATA_OUT while SCR_WE is high.
module scratch_ram
    import scratch_ram_pkg::*;
#(
    parameter int DATA_WIDTH = SCR_DATA_W,
    parameter int ADDR_WIDTH = SCR_ADDR_W
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    input  logic [ADDR_WIDTH-1:0] SCR_ADDR,
    input  logic                  SCR_WE,
    output logic [DATA_WIDTH-1:0] DATA_OUT
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (SCR_WE) mem_d[SCR_ADDR] = DATA_IN;
    end

    // Reset wins over any write sampled on the same edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

`ifdef SCRATCH_RAM_BYPASS_EN
    // Write-first: the single shared address means the pending write targets the word being read.
    assign DATA_OUT = (SCR_WE && !RST) ? DATA_IN : mem_q[SCR_ADDR];
`else
    assign DATA_OUT = mem_q[SCR_ADDR];
`endif
endmodule

// File: tb/tb_scratch_ram.sv
// tb_scratch_ram: self-checking bench for scratch_ram with a per-cycle array model.
module tb_scratch_ram;
    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [9:0] DATA_IN = '0;
    logic [7:0] SCR_ADDR = '0;
    logic       SCR_WE = 1'b0;
    logic [9:0] DATA_OUT;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    logic [9:0] model [256];

    scratch_ram dut (
        .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN),
        .SCR_ADDR(SCR_ADDR), .SCR_WE(SCR_WE), .DATA_OUT(DATA_OUT)
    );

    always #5 CLK = ~CLK;

    always @(posedge RST) foreach (model[k]) model[k] = '0;

    always @(posedge CLK) if (!RST && SCR_WE) model[SCR_ADDR] = DATA_IN;

    function automatic logic [9:0] model_out();
`ifdef SCRATCH_RAM_BYPASS_EN
        return SCR_WE ? DATA_IN : model[SCR_ADDR];
`else
        return model[SCR_ADDR];
`endif
    endfunction

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s addr=%0d got=0x%03h expected=0x%03h", name, SCR_ADDR, got, exp);
        end
    endtask

    always @(negedge CLK) if (chk_en && !RST) check("model", DATA_OUT, model_out());

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic sweep_zero(input string name);
        for (int a = 0; a < 256; a++) begin
            SCR_ADDR = 8'(a);
            #1 check(name, DATA_OUT, 10'h000);
        end
    endtask

    initial begin
        #1 RST = 1'b1;
        #2 RST = 1'b0;
        sweep_zero("reset_sweep");
        step();
        chk_en = 1'b1;

        SCR_ADDR = 8'd5; DATA_IN = 10'h0FF; SCR_WE = 1'b1;
        step();
        check("single_write", DATA_OUT, 10'h0FF);
        SCR_WE = 1'b0; SCR_ADDR = 8'd3;
        #1 check("other_addr_zero", DATA_OUT, 10'h000);
        SCR_ADDR = 8'd5;
        #1 check("readback_5", DATA_OUT, 10'h0FF);

        SCR_ADDR = 8'd10; DATA_IN = 10'h155; SCR_WE = 1'b0;
        repeat (3) step();
        check("we_low_no_write", DATA_OUT, 10'h000);

        for (int i = 0; i < 1023; i++) begin
            SCR_ADDR = 8'(i); DATA_IN = 10'(i); SCR_WE = 1'b1;
            step();
        end
        SCR_WE = 1'b0;
        for (int a = 0; a < 256; a++) begin
            SCR_ADDR = 8'(a);
            #1 check("wrap_last_wins", DATA_OUT, (a == 255) ? 10'd767 : 10'(768 + a));
        end
        step();

        SCR_ADDR = 8'd7; DATA_IN = 10'h012; SCR_WE = 1'b1;
        step();
        DATA_IN = 10'h3A5;
`ifdef SCRATCH_RAM_BYPASS_EN
        #1 check("rdw_before_edge", DATA_OUT, 10'h3A5);
`else
        #1 check("rdw_before_edge", DATA_OUT, 10'h012);
`endif
        step();
        check("rdw_after_edge", DATA_OUT, 10'h3A5);
        SCR_WE = 1'b0;
        step();

        SCR_ADDR = 8'd20; DATA_IN = 10'h2AA; SCR_WE = 1'b1;
        @(negedge CLK);
        #4 RST = 1'b1;
        #1 check("reset_async_clear", DATA_OUT, 10'h000);
        @(posedge CLK);
        #2 RST = 1'b0; SCR_WE = 1'b0;
        check("reset_write_lost", DATA_OUT, 10'h000);
        sweep_zero("reset_mid_write_sweep");
        step();

        SCR_ADDR = 8'd255; DATA_IN = 10'h3FF; SCR_WE = 1'b1;
        step();
        SCR_WE = 1'b0;
        check("max_addr_data", DATA_OUT, 10'h3FF);
        SCR_ADDR = 8'd0;
        #1 check("addr0_after_reset", DATA_OUT, 10'h000);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/scratch_ram.md
Name: scratch_ram

Overview:
- 256 x 10-bit scratch memory for the RAT CPU.
- Holds stack and scratch data. The control unit drives SCR_ADDR, SCR_WE and DATA_IN; DATA_OUT returns to the register file and PC mux.
- Writes are synchronous on the clock. Reads are combinational (asynchronous).
- Contents are held in flops so the whole array clears on reset.

Parameters:
- DATA_WIDTH, 10, word width in bits.
- ADDR_WIDTH, 8, address width in bits.
- DEPTH, 2**ADDR_WIDTH (256), number of words. Derived; not overridden independently.

Ports:
- CLK  input  1  system clock. All writes occur on its rising edge.
- RST  input  1  asynchronous, active-high reset. Clears every word to 0.
- DATA_IN  input  DATA_WIDTH  write data.
- SCR_ADDR  input  ADDR_WIDTH  shared read/write address.
- SCR_WE  input  1  write enable, active high, sampled on rising CLK.
- DATA_OUT  output  DATA_WIDTH  read data. Always equals the word at SCR_ADDR.

Behaviour:
- Interface: one clock (CLK). Reset RST is asynchronous and active-high.
- Reset:
  - RST high immediately forces all DEPTH words to 0, independent of CLK.
  - DATA_OUT therefore reads 0 at every address while RST is high and after release until written.
  - While RST is high, writes are ignored.
  - Reset asserted mid-operation discards any pending write on that edge.
- Write:
  - On rising CLK with RST low and SCR_WE = 1, mem[SCR_ADDR] <= DATA_IN.
  - One-cycle write latency; the new value is visible on DATA_OUT right after the edge.
  - SCR_WE = 0 leaves the array unchanged.
- Read:
  - DATA_OUT = mem[SCR_ADDR], purely combinational, zero latency. Address changes propagate without a clock.
  - Reading is independent of SCR_WE.
- Read-during-write, same address (macro off): DATA_OUT shows the old contents until the clock edge, then the new contents.
- Width rules:
  - Address is exactly ADDR_WIDTH bits; a wider source is truncated by the driver (address i maps to i mod 256).
  - DATA_IN is stored unmodified at DATA_WIDTH bits.
- No out-of-range condition exists: all 2**ADDR_WIDTH addresses are valid.
- Successive writes to the same address: the last write wins.
- No X on DATA_OUT after the first reset.

Optional Feature:
- SCRATCH_RAM_BYPASS_EN defined: when SCR_WE = 1, DATA_OUT = DATA_IN combinationally (write-first forwarding). This applies even before the edge, because read and write share the single address. Array update timing is unchanged.
- Undefined: DATA_OUT always shows the stored contents, as in the Behaviour section.

Decomposition:
- Package scratch_ram_pkg holds:
  - constants SCR_DATA_W = 10, SCR_ADDR_W = 8, SCR_DEPTH = 256;
  - typedefs scr_data_t (logic [9:0]) and scr_addr_t (logic [7:0]).
- Single module, no sub-modules: a flop array with an async-clear loop plus a read mux.
- A per-word cell sub-module is unnecessary.

Test Plan:
- Reset: pulse RST between clock edges, sweep SCR_ADDR 0..255 with SCR_WE = 0 -> DATA_OUT = 0 at every address, no clock needed for the clear.
- Single write: SCR_ADDR = 5, DATA_IN = 0x0FF, SCR_WE = 1, one rising edge -> DATA_OUT = 0x0FF at addr 5; then SCR_WE = 0, SCR_ADDR = 3 -> DATA_OUT = 0.
- Write disabled: SCR_WE = 0, DATA_IN = 0x155 at addr 10 over several edges -> addr 10 still reads 0.
- Wrap/overwrite: for i = 0..1022 write DATA_IN = i to SCR_ADDR = i mod 256, one per cycle; then read every address -> addr a (0..254) = 768 + a; addr 255 = 767.
- Async reset mid-write: assert RST with SCR_WE = 1 just before an edge -> the write is lost and all words read 0.
- Same-address read during write: hold addr 7 at 0x012, set DATA_IN = 0x3A5, SCR_WE = 1 -> before the edge DATA_OUT = 0x012 (0x3A5 with SCRATCH_RAM_BYPASS_EN); after the edge DATA_OUT = 0x3A5.
